frame_buf_arbiter: RTL

Burst scheduler for the single external frame-buffer port in the frame-difference pipeline. Shares the memory command channel between two streams: writing the current gray frame, and prefetching the previous frame that feeds `frame_adjacent_sync` (`gray_sdr` / `sdr_rd`). Ping-pongs two frame banks on each frame start. Sits between the gray-pixel write FIFO, the previous-frame read FIFO and the memory controller.

---
 rtl/frame_buf_arbiter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/frame_buf_arbiter.sv
// Frame-buffer burst arbiter: shares one memory command port between the gray-frame
// writer and the previous-frame prefetch, ping-ponging banks per frame. Option macro: FBA_READ_URGENT_EN.
module frame_buf_arbiter #(
    parameter int BURST_LEN = 16,
    parameter int FRAME_WORDS = 153600,
    parameter int ADDR_W = 20,
    parameter logic [ADDR_W-1:0] BANK0_BASE = 20'h00000,
    parameter logic [ADDR_W-1:0] BANK1_BASE = 20'h40000,
    parameter logic [9:0] RD_URGENT_SPACE = 10'd480
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vsync,
    input  logic [9:0]        wr_level,
    input  logic [9:0]        rd_space,
    output logic              mem_cmd_valid,
    input  logic              mem_cmd_ready,
    output logic              mem_cmd_we,
    output logic [ADDR_W-1:0] mem_cmd_addr,
    input  logic              mem_wr_beat,
    input  logic              mem_rd_beat,
    output logic              wr_bank,
    output logic              prev_valid,
    output logic              frame_short,
    output logic              busy
);

    localparam int CNT_W = $clog2(FRAME_WORDS + 1);
    localparam int BEAT_W = $clog2(BURST_LEN);
    localparam logic [CNT_W-1:0] FW = CNT_W'(FRAME_WORDS);
    localparam logic [CNT_W-1:0] BLC = CNT_W'(BURST_LEN);
    localparam logic [9:0] BL10 = 10'(BURST_LEN);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

`ifdef FBA_READ_URGENT_EN
    localparam bit URGENT_EN = 1'b1;
`else
    localparam bit URGENT_EN = 1'b0;
`endif

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] WR_CMD  = 3'd1;
    localparam logic [2:0] WR_DATA = 3'd2;
    localparam logic [2:0] RD_CMD  = 3'd3;
    localparam logic [2:0] RD_DATA = 3'd4;

    logic [2:0]        state;
    logic              vs_s1;
    logic              vs_s2;
    logic              swap_pending;
    logic              last_wr;
    logic [CNT_W-1:0]  wr_cnt;
    logic [CNT_W-1:0]  rd_cnt;
    logic [BEAT_W-1:0] beat_cnt;

    logic              vs_edge;
    logic              take_swap;
    logic              wr_elig;
    logic              rd_elig;
    logic              urgent;
    logic              grant_rd;
    logic              grant_wr;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;

    function automatic logic [CNT_W-1:0] advance(input logic [CNT_W-1:0] c);
        return (c >= FW - BLC) ? FW : c + BLC;
    endfunction

    assign vs_edge   = vs_s1 & ~vs_s2;
    assign take_swap = (state == IDLE) && swap_pending;
    assign wr_elig   = (wr_level >= BL10) && (wr_cnt < FW);
    assign rd_elig   = prev_valid && (rd_space >= BL10) && (rd_cnt < FW);
    assign urgent    = URGENT_EN && (rd_space > RD_URGENT_SPACE);
    assign grant_rd  = rd_elig && (!wr_elig || last_wr || urgent);
    assign grant_wr  = wr_elig && !grant_rd;
    assign wr_addr   = (wr_bank ? BANK1_BASE : BANK0_BASE) + ADDR_W'(wr_cnt);
    assign rd_addr   = (wr_bank ? BANK0_BASE : BANK1_BASE) + ADDR_W'(rd_cnt);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            vs_s1         <= 1'b0;
            vs_s2         <= 1'b0;
            swap_pending  <= 1'b0;
            last_wr       <= 1'b0;
            wr_cnt        <= '0;
            rd_cnt        <= '0;
            beat_cnt      <= '0;
            mem_cmd_valid <= 1'b0;
            mem_cmd_we    <= 1'b0;
            mem_cmd_addr  <= '0;
            wr_bank       <= 1'b0;
            prev_valid    <= 1'b0;
            frame_short   <= 1'b0;
        end else begin
            vs_s1        <= vsync;
            vs_s2        <= vs_s1;
            frame_short  <= 1'b0;
            // a fresh edge landing on the swap cycle must survive for the next frame
            swap_pending <= vs_edge | (swap_pending & ~take_swap);
            unique case (state)
                IDLE: begin
                    if (swap_pending) begin
                        wr_bank     <= ~wr_bank;
                        wr_cnt      <= '0;
                        rd_cnt      <= '0;
                        prev_valid  <= 1'b1;
                        frame_short <= prev_valid && (wr_cnt < FW);
                    end else if (grant_wr) begin
                        state         <= WR_CMD;
                        mem_cmd_valid <= 1'b1;
                        mem_cmd_we    <= 1'b1;
                        mem_cmd_addr  <= wr_addr;
                        last_wr       <= 1'b1;
                    end else if (grant_rd) begin
                        state         <= RD_CMD;
                        mem_cmd_valid <= 1'b1;
                        mem_cmd_we    <= 1'b0;
                        mem_cmd_addr  <= rd_addr;
                        last_wr       <= 1'b0;
                    end
                end
                WR_CMD: begin
                    if (mem_cmd_ready) begin
                        mem_cmd_valid <= 1'b0;
                        wr_cnt        <= advance(wr_cnt);
                        beat_cnt      <= '0;
                        state         <= WR_DATA;
                    end
                end
                WR_DATA: begin
                    if (mem_wr_beat) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (beat_cnt == LAST_BEAT) state <= IDLE;
                    end
                end
                RD_CMD: begin
                    if (mem_cmd_ready) begin
                        mem_cmd_valid <= 1'b0;
                        rd_cnt        <= advance(rd_cnt);
                        beat_cnt      <= '0;
                        state         <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (mem_rd_beat) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (beat_cnt == LAST_BEAT) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
